// File: rtl/rc4_crack_sequencer.sv
`default_nettype none
// rc4_crack_sequencer: steps each candidate key through the init/KSA/PRGA engines and muxes the S RAM.
// Optional per-phase watchdog: define RC4_WATCHDOG_EN.
module rc4_crack_sequencer #(
  parameter int              KEY_W       = 24,
  parameter logic [KEY_W-1:0] KEY_START  = '0,
  parameter logic [KEY_W-1:0] KEY_MAX    = KEY_W'(22'h3FFFFF),
  parameter int              WDOG_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             restart,
  input  logic             commenco,
  output logic             finito,
  output logic             found,
  output logic             timeout,
  output logic [KEY_W-1:0] key_out,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_done,
  input  logic             msg_ok,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       init_data,
  input  logic [7:0]       ksa_data,
  input  logic [7:0]       prga_data,
  input  logic             init_wen,
  input  logic             ksa_wen,
  input  logic             prga_wen,
  output logic [7:0]       s_address,
  output logic [7:0]       s_data,
  output logic             s_wen
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_GO   = 4'd1,
    INIT_WAIT = 4'd2,
    KSA_GO    = 4'd3,
    KSA_WAIT  = 4'd4,
    PRGA_GO   = 4'd5,
    PRGA_WAIT = 4'd6,
    CHECK     = 4'd7,
    NEXT_KEY  = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   start_search;
  logic   wdog_hit;

  assign start_search = commenco && (state == IDLE || state == DONE);
  assign finito       = (state == DONE);

  always_ff @(posedge clk) begin
    if (restart) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (commenco) state_nxt = INIT_GO;
      INIT_GO:   state_nxt = INIT_WAIT;
      INIT_WAIT: if (init_done) state_nxt = KSA_GO;   else if (wdog_hit) state_nxt = DONE;
      KSA_GO:    state_nxt = KSA_WAIT;
      KSA_WAIT:  if (ksa_done)  state_nxt = PRGA_GO;  else if (wdog_hit) state_nxt = DONE;
      PRGA_GO:   state_nxt = PRGA_WAIT;
      PRGA_WAIT: if (prga_done) state_nxt = CHECK;    else if (wdog_hit) state_nxt = DONE;
      CHECK:     state_nxt = (msg_ok || key_out == KEY_MAX) ? DONE : NEXT_KEY;
      NEXT_KEY:  state_nxt = INIT_GO;
      DONE:      if (commenco) state_nxt = INIT_GO;
      default:   state_nxt = IDLE;
    endcase
  end

  // Start pulses and RAM ownership are pure state decodes so the RAM port sees no extra latency.
  always_comb begin
    init_start = 1'b0;
    ksa_start  = 1'b0;
    prga_start = 1'b0;
    s_wen      = 1'b0;
    s_address  = 8'd0;
    s_data     = 8'd0;
    case (state)
      INIT_GO, INIT_WAIT: begin
        init_start = (state == INIT_GO);
        s_wen      = init_wen;
        s_address  = init_addr;
        s_data     = init_data;
      end
      KSA_GO, KSA_WAIT: begin
        ksa_start = (state == KSA_GO);
        s_wen     = ksa_wen;
        s_address = ksa_addr;
        s_data    = ksa_data;
      end
      PRGA_GO, PRGA_WAIT: begin
        prga_start = (state == PRGA_GO);
        s_wen      = prga_wen;
        s_address  = prga_addr;
        s_data     = prga_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      key_out <= KEY_START;
      found   <= 1'b0;
    end else if (start_search) begin
      key_out <= KEY_START;
      found   <= 1'b0;
    end else if (state == CHECK && msg_ok) begin
      found <= 1'b1;
    end else if (state == NEXT_KEY) begin
      key_out <= key_out + 1'b1;
    end
  end

`ifdef RC4_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic              in_wait;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout_q;

  assign in_wait  = (state == INIT_WAIT) || (state == KSA_WAIT) || (state == PRGA_WAIT);
  assign wdog_hit = in_wait && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign timeout  = timeout_q;

  // Counter rests at zero outside the wait states, so each wait phase starts a fresh budget.
  always_ff @(posedge clk) begin
    if (restart) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_cnt <= in_wait ? wdog_cnt + 1'b1 : '0;
      if (start_search) begin
        timeout_q <= 1'b0;
      end else if (in_wait && state_nxt == DONE) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rc4_crack_sequencer.sv
`default_nettype none
// tb_rc4_crack_sequencer: randomized engine models and a key-search reference model around the sequencer.
module tb_rc4_crack_sequencer;
  localparam int KEY_W = 24;
  localparam int KMAX  = 3;
  localparam int WDOG  = 16;

  logic             clk = 1'b0;
  logic             restart, commenco;
  logic             finito, found, timeout;
  logic [KEY_W-1:0] key_out;
  logic             init_start, ksa_start, prga_start;
  logic             init_done, ksa_done, prga_done, msg_ok;
  logic [7:0]       init_addr, ksa_addr, prga_addr;
  logic [7:0]       init_data, ksa_data, prga_data;
  logic             init_wen, ksa_wen, prga_wen;
  logic [7:0]       s_address, s_data;
  logic             s_wen;

  rc4_crack_sequencer #(
    .KEY_W(KEY_W), .KEY_START(24'd0), .KEY_MAX(24'd3), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .restart(restart), .commenco(commenco),
    .finito(finito), .found(found), .timeout(timeout), .key_out(key_out),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done), .msg_ok(msg_ok),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
    .init_wen(init_wen), .ksa_wen(ksa_wen), .prga_wen(prga_wen),
    .s_address(s_address), .s_data(s_data), .s_wen(s_wen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int owner = 0;       // 0 none, 1 init, 2 ksa, 3 prga engine holds the RAM
  int cnt = 0;
  int fixed_dly = 3;
  int good_key = -1;
  bit hang_prga = 1'b0;
  bit fixed_bus = 1'b0;
  bit done_prev = 1'b0;
  int starts[$];

  function automatic logic [16:0] exp_bus(input int own);
    case (own)
      1:       return {init_wen, init_addr, init_data};
      2:       return {ksa_wen, ksa_addr, ksa_data};
      3:       return {prga_wen, prga_addr, prga_data};
      default: return 17'd0;
    endcase
  endfunction

  function automatic bit starts_match(input int npass);
    if (starts.size() != npass * 3) return 1'b0;
    foreach (starts[i]) if (starts[i] != (i % 3) + 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_key();
    return (good_key >= 0 && good_key <= KMAX) ? good_key : KMAX;
  endfunction

  // One clock of engine behaviour: done pulses a fixed or random number of cycles after each start.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done_prev) owner = 0;
    done_prev = 1'b0;
    init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
    msg_ok = (good_key >= 0) && (key_out == KEY_W'(good_key));
    if (init_start || ksa_start || prga_start) begin
      if (init_start) starts.push_back(1);
      if (ksa_start)  starts.push_back(2);
      if (prga_start) starts.push_back(3);
      owner = init_start ? 1 : (ksa_start ? 2 : 3);
      cnt = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 5));
      if (owner == 3 && hang_prga) cnt = 0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        done_prev = 1'b1;
        case (owner)
          1: init_done = 1'b1;
          2: ksa_done  = 1'b1;
          3: prga_done = 1'b1;
          default: ;
        endcase
      end
    end
    if (fixed_bus) begin
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wen = 1'b1;
      ksa_addr  = 8'h55;        ksa_data  = 8'hA5;        ksa_wen  = 1'b1;
      prga_addr = 8'($urandom); prga_data = 8'($urandom); prga_wen = 1'b1;
    end else begin
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wen = 1'($urandom);
      ksa_addr  = 8'($urandom); ksa_data  = 8'($urandom); ksa_wen  = 1'($urandom);
      prga_addr = 8'($urandom); prga_data = 8'($urandom); prga_wen = 1'($urandom);
    end
    #1;
  endtask

  task automatic search(input int budget, output int first_start);
    bit ok;
    ok = 1'b0;
    first_start = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (first_start < 0 && starts.size() > 0) first_start = i;
      checks++;
      if ({s_wen, s_address, s_data} !== exp_bus(owner))
        $display("FAIL search_ram_mux: got %h want %h (owner %0d)", {s_wen, s_address, s_data}, exp_bus(owner), owner);
      else passes++;
      if (finito) begin
        commenco = 1'b0;
        ok = 1'b1;
        break;
      end
      commenco = 1'($urandom);
    end
    checks++;
    if (!ok) $display("FAIL search_budget: finito=%b after %0d cycles, want 1", finito, budget);
    else passes++;
  endtask

  task automatic check_outcome(input string tag);
    checks++;
    if (finito !== 1'b1) $display("FAIL %s_finito: got %b want 1", tag, finito); else passes++;
    checks++;
    if (found !== (good_key >= 0 && good_key <= KMAX))
      $display("FAIL %s_found: got %b want %b", tag, found, (good_key >= 0 && good_key <= KMAX));
    else passes++;
    checks++;
    if (key_out !== KEY_W'(exp_key())) $display("FAIL %s_key: got %0d want %0d", tag, key_out, exp_key()); else passes++;
    checks++;
    if (timeout !== 1'b0) $display("FAIL %s_timeout: got %b want 0", tag, timeout); else passes++;
    checks++;
    if (!starts_match(exp_key() + 1))
      $display("FAIL %s_start_seq: got %0d pulses want %0d in init/ksa/prga order", tag, starts.size(), 3 * (exp_key() + 1));
    else passes++;
  endtask

  task automatic test_reset();
    restart = 1'b1;
    commenco = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({finito, found, timeout, s_wen} !== 4'b0000)
        $display("FAIL reset_flags: got %b want 0000", {finito, found, timeout, s_wen});
      else passes++;
      checks++;
      if (key_out !== '0) $display("FAIL reset_key: got %0d want 0", key_out); else passes++;
      checks++;
      if ({init_start, ksa_start, prga_start} !== 3'b000)
        $display("FAIL reset_starts: got %b want 000", {init_start, ksa_start, prga_start});
      else passes++;
    end
    restart = 1'b0;
    commenco = 1'b0;
    step();
    checks++;
    if ({init_start, ksa_start, prga_start, finito} !== 4'b0000)
      $display("FAIL reset_idle: got %b want 0000", {init_start, ksa_start, prga_start, finito});
    else passes++;
    starts.delete();
    owner = 0; cnt = 0; done_prev = 1'b0;
  endtask

  task automatic test_single_key();
    int first;
    good_key = 0; fixed_dly = 3;
    starts.delete();
    commenco = 1'b1;
    search(200, first);
    check_outcome("single");
    checks++;
    if (first !== 1) $display("FAIL single_start_latency: got %0d want 1", first); else passes++;
    step();
    checks++;
    if (finito !== 1'b1 || found !== 1'b1 || starts.size() != 3)
      $display("FAIL single_done_hold: got finito=%b found=%b starts=%0d want 1 1 3", finito, found, starts.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    int first;
    good_key = 2; fixed_dly = 0;
    starts.delete();
    commenco = 1'b1;
    step();
    commenco = 1'b0;
    checks++;
    if ({finito, found, init_start} !== 3'b001 || key_out !== '0)
      $display("FAIL b2b_restart: got finito=%b found=%b init_start=%b key=%0d want 0 0 1 0",
               finito, found, init_start, key_out);
    else passes++;
    search(400, first);
    check_outcome("b2b");
  endtask

  task automatic test_exhaust();
    int first;
    good_key = -1; fixed_dly = 0;
    starts.delete();
    commenco = 1'b1;
    search(600, first);
    check_outcome("exhaust");
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (starts.size() != 3 * (KMAX + 1) || finito !== 1'b1)
      $display("FAIL exhaust_no_wrap: got %0d pulses finito=%b want %0d 1", starts.size(), finito, 3 * (KMAX + 1));
    else passes++;
  endtask

  task automatic test_arbitration();
    bit saw_ksa, saw_idle;
    good_key = 0; fixed_dly = 3; fixed_bus = 1'b1;
    saw_ksa = 1'b0; saw_idle = 1'b0;
    starts.delete();
    commenco = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      commenco = 1'b0;
      if (owner == 2 && !ksa_start) begin
        saw_ksa = 1'b1;
        checks++;
        if ({s_wen, s_address, s_data} !== {1'b1, 8'h55, 8'hA5})
          $display("FAIL arb_ksa_wait: got %h want 155a5", {s_wen, s_address, s_data});
        else passes++;
      end
      if (owner == 0 && starts.size() == 3) begin
        saw_idle = 1'b1;
        checks++;
        if (s_wen !== 1'b0) $display("FAIL arb_check_wen: got %b want 0", s_wen); else passes++;
      end
      if (finito) break;
    end
    checks++;
    if (!(saw_ksa && saw_idle)) $display("FAIL arb_coverage: got ksa=%b idle=%b want 1 1", saw_ksa, saw_idle);
    else passes++;
    fixed_bus = 1'b0;
  endtask

  task automatic test_mid_reset();
    int nprga;
    good_key = 2; fixed_dly = 4; fixed_bus = 1'b1;
    starts.delete();
    commenco = 1'b1;
    nprga = 0;
    for (int i = 0; i < 200 && nprga < 2; i++) begin
      step();
      commenco = 1'b0;
      if (prga_start) nprga++;
    end
    step();
    checks++;
    if (owner !== 3 || key_out !== KEY_W'(1))
      $display("FAIL midrst_setup: got owner=%0d key=%0d want 3 1", owner, key_out);
    else passes++;
    restart = 1'b1;
    cnt = 0;
    step();
    owner = 0; done_prev = 1'b0;
    checks++;
    if ({finito, found, timeout, s_wen, init_start, ksa_start, prga_start} !== 7'd0 || key_out !== '0)
      $display("FAIL midrst_outputs: got %b key=%0d want 0000000 0",
               {finito, found, timeout, s_wen, init_start, ksa_start, prga_start}, key_out);
    else passes++;
    restart = 1'b0;
    step();
    checks++;
    if ({init_start, ksa_start, prga_start, finito, s_wen} !== 5'd0)
      $display("FAIL midrst_idle: got %b want 00000", {init_start, ksa_start, prga_start, finito, s_wen});
    else passes++;
    fixed_bus = 1'b0;
  endtask

`ifdef RC4_WATCHDOG_EN
  task automatic test_watchdog();
    int p, f;
    good_key = 0; fixed_dly = 2; hang_prga = 1'b1;
    p = -1; f = -1;
    commenco = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      commenco = 1'b0;
      if (prga_start) p = cyc;
      if (finito) begin f = cyc; break; end
    end
    checks++;
    if (finito !== 1'b1 || timeout !== 1'b1 || found !== 1'b0)
      $display("FAIL wdog_flags: got finito=%b timeout=%b found=%b want 1 1 0", finito, timeout, found);
    else passes++;
    checks++;
    if (p < 0 || f - p != WDOG + 1) $display("FAIL wdog_latency: got %0d want %0d", f - p, WDOG + 1);
    else passes++;
    hang_prga = 1'b0;
  endtask
`endif

  initial begin
    restart = 1'b1; commenco = 1'b0; msg_ok = 1'b0;
    init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
    init_addr = 8'd0; ksa_addr = 8'd0; prga_addr = 8'd0;
    init_data = 8'd0; ksa_data = 8'd0; prga_data = 8'd0;
    init_wen = 1'b0; ksa_wen = 1'b0; prga_wen = 1'b0;
    test_reset();
    test_single_key();
    test_back_to_back();
    test_exhaust();
    test_arbitration();
    test_mid_reset();
`ifdef RC4_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
